// File: rtl/video_pkg.sv
// Shared VGA 640x480@60 timing constants and small types, also used by the upscaler.
package video_pkg;

  localparam int unsigned H_VIS   = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VIS   = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned CNT_W   = 10;

  typedef enum logic {
    MODE_2X = 1'b0,
    MODE_1X = 1'b1
  } scale_mode_e;

  // Per-pixel control bits carried down the pipeline alongside the RAM read.
  typedef struct packed {
    logic hsync_act;
    logic vsync_act;
    logic vis;
    logic win;
    logic first;
  } vid_ctl_t;

endpackage

// File: rtl/vga_framebuffer_scan_timing.sv
// Raster counters and sync/visible decode for the 640x480 scan.
module vga_timing
  import video_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hsync_act_o,
  output logic             vsync_act_o,
  output logic             vis_o,
  output logic             first_o,
  output logic             last_o
);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             h_wrap, v_wrap;

  always_comb begin
    h_wrap = (h_q == CNT_W'(H_TOTAL - 1));
    v_wrap = (v_q == CNT_W'(V_TOTAL - 1));
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o     = h_q;
  assign v_cnt_o     = v_q;
  assign hsync_act_o = (h_q >= CNT_W'(H_VIS + H_FP)) && (h_q < CNT_W'(H_VIS + H_FP + H_SYNC));
  assign vsync_act_o = (v_q >= CNT_W'(V_VIS + V_FP)) && (v_q < CNT_W'(V_VIS + V_FP + V_SYNC));
  assign vis_o       = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
  assign first_o     = (h_q == '0) && (v_q == '0);
  assign last_o      = h_wrap && v_wrap;

endmodule

// File: rtl/vga_framebuffer_scan.sv
// Scans the framebuffer RAM in 1x (640x480) or centred 2x (320x240) geometry and
// drives VGA pins through a 3-stage pipeline matching the RAM read latency.
module vga_framebuffer_scan
  import video_pkg::*;
#(
  parameter int unsigned SRC_LARG = 160,
  parameter int unsigned SRC_ALT  = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw,
  input  logic              src_done,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [7:0]        ram_q,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start
);

  localparam int unsigned WIN_W = 2 * SRC_LARG;
  localparam int unsigned WIN_H = 2 * SRC_ALT;
  localparam int unsigned X0    = (H_VIS - WIN_W) / 2;
  localparam int unsigned Y0    = (V_VIS - WIN_H) / 2;

  logic [CNT_W-1:0]  h, v, dh, dv;
  logic              hs_act, vs_act, vis, first, last;
  scale_mode_e       mode_q;
  logic              en_q;
  vid_ctl_t          ctl_d, s1_q, s2_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [7:0]        pix_d, pix_q;
  logic              hsync_q, vsync_q, blank_n_q, fs_q;

  vga_timing u_timing (
    .clk_i       (clk),
    .rst_i       (reset),
    .h_cnt_o     (h),
    .v_cnt_o     (v),
    .hsync_act_o (hs_act),
    .vsync_act_o (vs_act),
    .vis_o       (vis),
    .first_o     (first),
    .last_o      (last)
  );

  // Strides 640 = 512+128 and 320 = 256+64 as shift-adds; 307199 fits in 19 bits.
  always_comb begin
    dh              = h - CNT_W'(X0);
    dv              = v - CNT_W'(Y0);
    ctl_d           = '0;
    ctl_d.hsync_act = hs_act;
    ctl_d.vsync_act = vs_act;
    ctl_d.vis       = vis;
    ctl_d.first     = first;
    addr_d          = '0;
    if (mode_q == MODE_1X) begin
      ctl_d.win = vis;
      if (vis) begin
        addr_d = (ADDR_W'(v) << 9) + (ADDR_W'(v) << 7) + ADDR_W'(h);
      end
    end else begin
      ctl_d.win = (h >= CNT_W'(X0)) && (h < CNT_W'(X0 + WIN_W)) &&
                  (v >= CNT_W'(Y0)) && (v < CNT_W'(Y0 + WIN_H));
      if (ctl_d.win) begin
        addr_d = (ADDR_W'(dv) << 8) + (ADDR_W'(dv) << 6) + ADDR_W'(dh);
      end
    end
  end

  assign pix_d = (s2_q.win && s2_q.vis && en_q) ? ram_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_2X;
      en_q      <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      addr_q    <= '0;
      pix_q     <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      if (last) begin
        mode_q <= scale_mode_e'(sw);
        en_q   <= src_done;
      end
      s1_q      <= ctl_d;
      s2_q      <= s1_q;
      addr_q    <= addr_d;
      pix_q     <= pix_d;
      hsync_q   <= ~s2_q.hsync_act;
      vsync_q   <= ~s2_q.vsync_act;
      blank_n_q <= s2_q.vis;
      fs_q      <= s2_q.first;
    end
  end

  assign ram_rdaddr  = addr_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_blank_n = blank_n_q;
  assign vga_r       = pix_q;
  assign vga_g       = pix_q;
  assign vga_b       = pix_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_framebuffer_scan.sv
// Bench for vga_framebuffer_scan: raster-position reference model, RAM model, vector table.
module tb_vga_framebuffer_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        sw, src_done;
  logic [18:0] ram_rdaddr;
  logic [7:0]  ram_q;
  logic        vga_hsync, vga_vsync, vga_blank_n, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_framebuffer_scan #(.SRC_LARG(160), .SRC_ALT(120)) dut (
    .clk         (clk),
    .reset       (reset),
    .sw          (sw),
    .src_done    (src_done),
    .ram_rdaddr  (ram_rdaddr),
    .ram_q       (ram_q),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_blank_n (vga_blank_n),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned seed;
  bit          const_ff;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  function automatic logic [7:0] ram_hash(input logic [18:0] a);
    logic [31:0] x;
    x = ({13'd0, a} ^ seed) * 32'h9E3779B1;
    return x[23:16];
  endfunction

  function automatic logic [7:0] ram_fn(input logic [18:0] a);
    if (const_ff) return 8'hFF;
    if (a == 19'd1285) return 8'hA5;
    return ram_hash(a);
  endfunction

  always @(posedge clk) ram_q <= ram_fn(ram_rdaddr);

  // Reference: expected pins for raster position p (cycles since reset release).
  typedef struct packed {
    logic        hs, vs, bl, fs;
    logic [7:0]  px;
    logic [18:0] addr;
  } exp_t;

  function automatic exp_t model(input int unsigned p, input bit mode, input bit en);
    int unsigned h, v;
    bit          vis, win;
    exp_t        r;
    h   = p % 800;
    v   = (p / 800) % 525;
    vis = (h < 640) && (v < 480);
    win = mode ? vis : ((h >= 160) && (h < 480) && (v >= 120) && (v < 360));
    if (!win)     r.addr = 19'd0;
    else if (mode) r.addr = 19'(v * 640 + h);
    else          r.addr = 19'((v - 120) * 320 + (h - 160));
    r.hs = !((h >= 656) && (h < 752));
    r.vs = !((v == 490) || (v == 491));
    r.bl = vis;
    r.fs = (p % 420000) == 0;
    r.px = (win && en) ? ram_fn(r.addr) : 8'd0;
    return r;
  endfunction

  exp_t        q[$];
  int unsigned e;
  bit          m_mode, m_en;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      e      = 0;
      m_mode = 1'b0;
      m_en   = 1'b0;
    end else begin
      q.push_back(model(e, m_mode, m_en));
      if (q.size() > 3) void'(q.pop_front());
      if (e % 420000 == 419999) begin
        m_mode = sw;
        m_en   = src_done;
      end
      e++;
    end
  end

  exp_t        x;
  logic [18:0] xa;
  initial forever begin
    @(negedge clk);
    if (q.size() >= 3) x = q[0];
    else x = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0, px: 8'd0, addr: 19'd0};
    xa = (q.size() > 0) ? q[q.size()-1].addr : 19'd0;
    check("stream{hs,vs,bl,fs,r,g,b,addr}",
          64'({vga_hsync, vga_vsync, vga_blank_n, frame_start, vga_r, vga_g, vga_b, ram_rdaddr}),
          64'({x.hs, x.vs, x.bl, x.fs, x.px, x.px, x.px, xa}));
  end

  // Pin-level timing measurements.
  int  cyc = 0, last_fall = 0, hs_period = 0, hs_run = 0, hs_width = 0;
  int  vs_low = 0, bl_run = 0, bl_runs = 0, bl_bad = 0;
  bit  prev_hs = 1'b1, prev_bl = 1'b0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (prev_hs && !vga_hsync) begin
      if (last_fall > 0) hs_period = cyc - last_fall;
      last_fall = cyc;
    end
    if (!vga_hsync) hs_run++;
    else if (!prev_hs) begin
      hs_width = hs_run;
      hs_run   = 0;
    end
    if (!vga_vsync) vs_low++;
    if (vga_blank_n) bl_run++;
    else if (prev_bl) begin
      bl_runs++;
      if (bl_run != 640) bl_bad++;
      bl_run = 0;
    end
    prev_hs = vga_hsync;
    prev_bl = vga_blank_n;
  end

  typedef struct {
    int unsigned p;
    logic [18:0] addr;
    logic [7:0]  px;
  } vec_t;
  vec_t tbl[11];

  function automatic int unsigned pos(input int unsigned f, input int unsigned h, input int unsigned v);
    return f * 420000 + v * 800 + h;
  endfunction

  task automatic run_to(input int unsigned target);
    while (e < target) begin
      @(posedge clk);
      #1;
      if (e < 400000) begin
        if ($urandom_range(0, 3999) == 0) sw = ~sw;
        if ($urandom_range(0, 3999) == 0) src_done = ~src_done;
      end
      if (e == 160000) sw = ~sw;
      if (e == 200000) src_done = 1'b1;
      if (e == 400000) begin
        sw       = 1'b1;
        src_done = 1'b1;
        const_ff = 1'b0;
      end
      for (int i = 0; i < 11; i++) begin
        if (tbl[i].p + 1 == e)
          check($sformatf("tbl%0d_rdaddr", i), 64'(ram_rdaddr), 64'(tbl[i].addr));
        if (tbl[i].p + 3 == e)
          check($sformatf("tbl%0d_rgb", i), 64'({vga_r, vga_g, vga_b}), 64'({3{tbl[i].px}}));
      end
    end
  endtask

  initial begin
    seed     = $urandom;
    const_ff = 1'b1;
    sw       = 1'b0;
    src_done = 1'b0;
    reset    = 1'b1;

    tbl[0]  = '{pos(0, 0, 0),     19'd0,     8'd0};
    tbl[1]  = '{pos(0, 159, 120), 19'd0,     8'd0};
    tbl[2]  = '{pos(0, 160, 120), 19'd0,     8'd0};
    tbl[3]  = '{pos(0, 200, 130), 19'd3240,  8'd0};
    tbl[4]  = '{pos(0, 480, 200), 19'd0,     8'd0};
    tbl[5]  = '{pos(0, 320, 240), 19'd38560, 8'd0};
    tbl[6]  = '{pos(0, 479, 359), 19'd76799, 8'd0};
    tbl[7]  = '{pos(1, 0, 0),     19'd0,     ram_hash(19'd0)};
    tbl[8]  = '{pos(1, 640, 0),   19'd0,     8'd0};
    tbl[9]  = '{pos(1, 5, 2),     19'd1285,  8'hA5};
    tbl[10] = '{pos(1, 639, 3),   19'd2559,  ram_hash(19'd2559)};

    repeat (5) @(posedge clk);
    #1;
    check("reset_pins{hs,vs,bl,fs,rgb,addr}",
          64'({vga_hsync, vga_vsync, vga_blank_n, frame_start, vga_r, vga_g, vga_b, ram_rdaddr}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 24'd0, 19'd0}));
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("frame_start_edge%0d", k), 64'(frame_start), 64'(k == 3));
    end

    // Frame 0 in 2x/black, frame 1 in 1x with pixels; abort mid-line in frame 1.
    run_to(pos(1, 770, 3));
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run_to(pos(0, 100, 3));

    check("hsync_period", 64'(hs_period), 64'd800);
    check("hsync_low_width", 64'(hs_width), 64'd96);
    check("vsync_low_cycles", 64'(vs_low), 64'd1600);
    check("blank_runs_not_640", 64'(bl_bad), 64'd0);
    check("blank_runs_seen", 64'(bl_runs >= 480), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
